issue_queue_ctrl: RTL and testbench

Dual-issue instruction queue and sequencer between the fetch stage and the instruction scheduler. Buffers 128-bit fetch packets (two {instr, pc} slots) in a circular buffer and always presents the two oldest instructions to the scheduler. Retires 0, 1 or 2 entries per cycle according to how many the scheduler actually issued. Back-pressures fetch when full and flushes on a control-flow redirect.

---
 rtl/issue_queue_ctrl.sv | 115 +++++++++++
 tb/tb_issue_queue_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_ctrl.sv
// issue_queue_ctrl: dual-issue instruction queue between fetch and scheduler.
// Buffers 128-bit fetch packets (two {instr, pc} slots) in a circular buffer
// of DEPTH 64-bit entries. The two oldest entries are always presented to the
// scheduler, and 0..2 entries are retired per cycle as the scheduler issues them.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   fetch_valid  fetch packet present
//   fetch_data   [63:0] = {instr0, pc0} (older), [127:64] = {instr1, pc1}
//   fetch_ready  queue has room for a full packet (from registered count)
//   sched_data   two oldest entries in the same slot format; invalid slots are 0
//   sched_valid  bit0 = slot0 valid, bit1 = slot1 valid
//   issue_cnt    entries consumed by the scheduler this cycle
//   flush        control-flow redirect, empties the queue at the next edge
//   count        current occupancy
//
// Optional feature: define ISSUE_QUEUE_BYPASS_EN to present an incoming packet
// directly when the queue is empty (0-cycle latency). The default build has
// no combinational path from fetch inputs to scheduler outputs.
module issue_queue_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_valid,
  input  logic [127:0]             fetch_data,
  output logic                     fetch_ready,
  output logic [127:0]             sched_data,
  output logic [1:0]               sched_valid,
  input  logic [1:0]               issue_cnt,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW-1:0] wptr1, rptr1;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] eff;
  logic [CW-1:0] n_wr;
  logic          accept;
  logic          wr_en0, wr_en1;
  logic [63:0]   wr_d0, wr_d1;

  assign wptr1       = wptr + PW'(1);
  assign rptr1       = rptr + PW'(1);
  assign count       = cnt_q;
  assign fetch_ready = (cnt_q <= CW'(DEPTH - 2));

  always_comb begin
    sched_valid = {cnt_q >= CW'(2), cnt_q != '0};
    sched_data  = '0;
    if (sched_valid[0]) sched_data[63:0]   = mem[rptr];
    if (sched_valid[1]) sched_data[127:64] = mem[rptr1];

    accept = fetch_valid && fetch_ready && !flush;
    // Over-issue (including issue_cnt = 3) is clamped to what is held.
    eff    = (CW'(issue_cnt) > cnt_q) ? cnt_q : CW'(issue_cnt);

    wr_en0 = accept;
    wr_en1 = accept;
    wr_d0  = fetch_data[63:0];
    wr_d1  = fetch_data[127:64];
    n_wr   = accept ? CW'(2) : '0;

`ifdef ISSUE_QUEUE_BYPASS_EN
    // Empty queue: the packet goes straight to the scheduler. Only slots it
    // did not consume are stored, packed from wptr so order is preserved.
    if ((cnt_q == '0) && fetch_valid && !flush) begin
      sched_data  = fetch_data;
      sched_valid = 2'b11;
      case (issue_cnt)
        2'd0: ;
        2'd1: begin
          wr_en1 = 1'b0;
          wr_d0  = fetch_data[127:64];
          n_wr   = CW'(1);
        end
        default: begin
          wr_en0 = 1'b0;
          wr_en1 = 1'b0;
          n_wr   = '0;
        end
      endcase
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
    end else begin
      wptr  <= wptr + n_wr[PW-1:0];
      rptr  <= rptr + eff[PW-1:0];
      cnt_q <= cnt_q + n_wr - eff;
    end
  end

  // Entry storage is intentionally not reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (wr_en0) mem[wptr]  <= wr_d0;
    if (wr_en1) mem[wptr1] <= wr_d1;
  end

endmodule

// File: tb/tb_issue_queue_ctrl.sv
module tb_issue_queue_ctrl;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fetch_valid = 1'b0;
  logic [127:0] fetch_data = '0;
  logic [1:0]   issue_cnt = '0;
  logic         flush = 1'b0;
  logic         fetch_ready;
  logic [127:0] sched_data;
  logic [1:0]   sched_valid;
  logic [3:0]   count;

  issue_queue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_ready (fetch_ready),
    .sched_data  (sched_data),
    .sched_valid (sched_valid),
    .issue_cnt   (issue_cnt),
    .flush       (flush),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         fv;
    logic [127:0] data;
    logic [1:0]   ic;
    logic         fl;
    logic [3:0]   exp_count;
    logic [1:0]   exp_valid;
    logic         exp_ready;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [63:0]  model [$];   // reference queue contents, oldest first
  logic [127:0] sb [$];      // expected sched_data, pushed when driven

  function automatic logic [127:0] pkt(input logic [31:0] pc);
    logic [31:0] pc1;
    pc1 = pc + 32'd4;
    return {32'hA000_0000 | pc1, pc1, 32'hA000_0000 | pc, pc};
  endfunction

  function automatic vec_t mk(input logic fv, input logic [127:0] data,
                              input logic [1:0] ic, input logic fl,
                              input logic [3:0] c, input logic [1:0] v,
                              input logic r);
    vec_t t;
    t.fv = fv; t.data = data; t.ic = ic; t.fl = fl;
    t.exp_count = c; t.exp_valid = v; t.exp_ready = r;
    return t;
  endfunction

  function automatic logic [127:0] model_out();
    logic [127:0] d;
    d = '0;
    if (model.size() >= 1) d[63:0]   = model[0];
    if (model.size() >= 2) d[127:64] = model[1];
    return d;
  endfunction

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    int sz;
    int eff;
    logic acc;
    @(negedge clk);
    fetch_valid = v.fv;
    fetch_data  = v.data;
    issue_cnt   = v.ic;
    flush       = v.fl;
    sz  = model.size();
    if (!v.fl && int'(v.ic) > sz)
      $display("[TB] protocol error: issue_cnt %0d with count %0d at vector %0d", v.ic, sz, idx);
    if (v.fl) begin
      model.delete();
    end else begin
      acc = v.fv && (DEPTH - sz >= 2);
      eff = (int'(v.ic) > sz) ? sz : int'(v.ic);
      repeat (eff) void'(model.pop_front());
      if (acc) begin
        model.push_back(v.data[63:0]);
        model.push_back(v.data[127:64]);
      end
    end
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    check($sformatf("count[%0d]", idx), 128'(count), 128'(v.exp_count));
    check($sformatf("sched_valid[%0d]", idx), 128'(sched_valid), 128'(v.exp_valid));
    check($sformatf("fetch_ready[%0d]", idx), 128'(fetch_ready), 128'(v.exp_ready));
    check($sformatf("sched_data[%0d]", idx), sched_data, sb.pop_front());
    if (sched_valid == 2'b11)
      check($sformatf("pc_order[%0d]", idx), 128'(sched_data[95:64]),
            128'(sched_data[31:0] + 32'd4));
  endtask

  vec_t vecs [$];

  initial begin
    logic [127:0] spec_pkt;
    spec_pkt = 128'h0001E237_00000004_00014137_00000000;

    // single packet, partial issue
    vecs.push_back(mk(1, spec_pkt,    0, 0, 2, 2'b11, 1));
    vecs.push_back(mk(0, '0,          1, 0, 1, 2'b01, 1));
    vecs.push_back(mk(0, '0,          1, 0, 0, 2'b00, 1));
    // fill to full across the wrap point
    vecs.push_back(mk(1, pkt(32'h10), 0, 0, 2, 2'b11, 1));
    vecs.push_back(mk(1, pkt(32'h18), 0, 0, 4, 2'b11, 1));
    vecs.push_back(mk(1, pkt(32'h20), 0, 0, 6, 2'b11, 1));
    vecs.push_back(mk(1, pkt(32'h28), 0, 0, 8, 2'b11, 0));
    vecs.push_back(mk(1, pkt(32'h30), 0, 0, 8, 2'b11, 0));  // rejected when full
    vecs.push_back(mk(0, '0,          2, 0, 6, 2'b11, 1));
    vecs.push_back(mk(1, pkt(32'h30), 2, 0, 6, 2'b11, 1));  // accept+retire at full-2
    vecs.push_back(mk(1, pkt(32'h38), 0, 0, 8, 2'b11, 0));
    vecs.push_back(mk(0, '0,          2, 0, 6, 2'b11, 1));
    vecs.push_back(mk(0, '0,          2, 0, 4, 2'b11, 1));
    vecs.push_back(mk(0, '0,          2, 0, 2, 2'b11, 1));
    vecs.push_back(mk(0, '0,          2, 0, 0, 2'b00, 1));
    // flush with 6 entries, concurrent fetch and issue discarded
    vecs.push_back(mk(1, pkt(32'h40), 0, 0, 2, 2'b11, 1));
    vecs.push_back(mk(1, pkt(32'h48), 0, 0, 4, 2'b11, 1));
    vecs.push_back(mk(1, pkt(32'h50), 0, 0, 6, 2'b11, 1));
    vecs.push_back(mk(1, pkt(32'h58), 2, 1, 0, 2'b00, 1));
    vecs.push_back(mk(0, '0,          0, 0, 0, 2'b00, 1));
    // sustained two per cycle
    vecs.push_back(mk(1, pkt(32'h60), 0, 0, 2, 2'b11, 1));
    vecs.push_back(mk(1, pkt(32'h68), 2, 0, 2, 2'b11, 1));
    vecs.push_back(mk(1, pkt(32'h70), 2, 0, 2, 2'b11, 1));
    vecs.push_back(mk(1, pkt(32'h78), 2, 0, 2, 2'b11, 1));
    vecs.push_back(mk(0, '0,          2, 0, 0, 2'b00, 1));

    // reset held, then released
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 128'(count), 128'(0));
    check("rst_valid", 128'(sched_valid), 128'(0));
    check("rst_ready", 128'(fetch_ready), 128'(1));
    check("rst_data", sched_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_count", 128'(count), 128'(0));
    check("post_rst_valid", 128'(sched_valid), 128'(0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i);
      if (i == 0) check("spec_slots", sched_data, spec_pkt);
      if (i == 1) check("spec_slot0_shift", sched_data,
                        {64'h0, 64'h0001E237_00000004});
    end

    // asynchronous reset between edges with four entries held
    step(mk(1, pkt(32'h80), 0, 0, 2, 2'b11, 1), 100);
    step(mk(1, pkt(32'h88), 0, 0, 4, 2'b11, 1), 101);
    @(negedge clk);
    fetch_valid = 1'b0;
    issue_cnt   = 2'd0;
    flush       = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 128'(count), 128'(0));
    check("arst_valid", 128'(sched_valid), 128'(0));
    check("arst_ready", 128'(fetch_ready), 128'(1));
    check("arst_data", sched_data, '0);
    model.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(1, pkt(32'h90), 0, 0, 2, 2'b11, 1), 102);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
